// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//
// Clock-domain controller for the CPU core clock. Runs entirely on the PLL output
// clock: qualifies PLL lock (2-flop synchronizer + stability filter), sequences a
// stretched CPU reset, then gates core activity with a registered clock-enable under
// RUN / HALT / single-STEP control.
//
// Parameters:
//   LOCK_STABLE  consecutive synchronized-lock cycles needed to leave WAIT_LOCK (>=1)
//   RST_CYCLES   cycles cpu_rst_n is held low once lock qualifies (>=1)
//   STEP_CYCLES  enabled cycles per single-step request (>=1)
//   AUTO_RUN     1: enter RUN after the reset sequence, 0: enter HALT
//
// Ports:
//   cpu_clk     in   PLL output clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   clk_lock    in   PLL locked, asynchronous to cpu_clk
//   run_req     in   level, rising edge requests RUN
//   halt_req    in   level, high requests HALT
//   step_req    in   level, rising edge requests one step
//   bp_hit      in   single-cycle breakpoint pulse from the CPU
//   cpu_rst_n   out  registered active-low CPU reset
//   cpu_en      out  registered CPU clock-enable
//   ctrl_state  out  WAIT_LOCK=0, RST_HOLD=1, HALT=2, RUN=3, STEP=4
//   cycle_cnt   out  number of cycles with cpu_en=1 (wraps)

module cpu_clk_ctrl #(
    parameter int unsigned LOCK_STABLE = 8,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned STEP_CYCLES = 1,
    parameter bit          AUTO_RUN    = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        clk_lock,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        bp_hit,
    output logic        cpu_rst_n,
    output logic        cpu_en,
    output logic [2:0]  ctrl_state,
    output logic [31:0] cycle_cnt
);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StRstHold  = 3'd1,
        StHalt     = 3'd2,
        StRun      = 3'd3,
        StStep     = 3'd4
    } state_e;

    // One counter serves both the lock filter and the reset stretch.
    localparam int unsigned CNT_MAX = (LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned STEP_W  = $clog2(STEP_CYCLES + 1);

    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_run_q;
    logic              r_run_rise;
    logic              r_step_q;
    logic              r_step_rise;
    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_cpu_rst_n;
    logic              r_cpu_en;
    logic [31:0]       r_cycle_cnt;

    state_e            w_state_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [STEP_W-1:0] w_step_cnt_d;
    logic              w_cpu_rst_n_d;
    logic              w_cpu_en_d;
    logic [31:0]       w_cycle_cnt_d;

    // Lock synchronizer and request edge detectors. The rise itself is registered,
    // so a request rising before edge k acts at edge k+1.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_run_q     <= 1'b0;
            r_run_rise  <= 1'b0;
            r_step_q    <= 1'b0;
            r_step_rise <= 1'b0;
        end else begin
            r_lock_meta <= clk_lock;
            r_lock_s    <= r_lock_meta;
            r_run_q     <= run_req;
            r_run_rise  <= run_req & ~r_run_q;
            r_step_q    <= step_req;
            r_step_rise <= step_req & ~r_step_q;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StWaitLock;
            r_cnt       <= '0;
            r_step_cnt  <= '0;
            r_cpu_rst_n <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_step_cnt  <= w_step_cnt_d;
            r_cpu_rst_n <= w_cpu_rst_n_d;
            r_cpu_en    <= w_cpu_en_d;
            r_cycle_cnt <= w_cycle_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_step_cnt_d = r_step_cnt;
        w_cnt_inc    = r_cnt + 1'b1;

        if ((r_state != StWaitLock) && !r_lock_s) begin
            // Lock loss overrides every request.
            w_state_d = StWaitLock;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                StWaitLock: begin
                    if (!r_lock_s) begin
                        w_cnt_d = '0;
                    end else if (w_cnt_inc == CNT_W'(LOCK_STABLE)) begin
                        w_state_d = StRstHold;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StRstHold: begin
                    if (w_cnt_inc == CNT_W'(RST_CYCLES)) begin
                        w_state_d = AUTO_RUN ? StRun : StHalt;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StRun: begin
                    if (halt_req || bp_hit) begin
                        w_state_d = StHalt;
                    end
                end
                StHalt: begin
                    if (halt_req) begin
                        w_state_d = StHalt;
                    end else if (r_step_rise) begin
                        w_state_d    = StStep;
                        w_step_cnt_d = STEP_W'(STEP_CYCLES);
                    end else if (r_run_rise) begin
                        w_state_d = StRun;
                    end
                end
                StStep: begin
                    // All requests are ignored until the step burst completes.
                    if (r_step_cnt <= STEP_W'(1)) begin
                        w_state_d    = StHalt;
                        w_step_cnt_d = '0;
                    end else begin
                        w_step_cnt_d = r_step_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_d = StWaitLock;
                    w_cnt_d   = '0;
                end
            endcase
        end

        w_cpu_rst_n_d = (w_state_d == StHalt) || (w_state_d == StRun) || (w_state_d == StStep);
        w_cpu_en_d    = (w_state_d == StRun) || (w_state_d == StStep);

        // Clear from the next reset value so the count reads 0 on the same edge the
        // CPU enters reset; increment on the current (registered) enable.
        if (!w_cpu_rst_n_d) begin
            w_cycle_cnt_d = '0;
        end else if (r_cpu_en) begin
            w_cycle_cnt_d = r_cycle_cnt + 32'd1;
        end else begin
            w_cycle_cnt_d = r_cycle_cnt;
        end
    end

    assign cpu_rst_n  = r_cpu_rst_n;
    assign cpu_en     = r_cpu_en;
    assign ctrl_state = r_state;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Testbench for cpu_clk_ctrl: two instances (defaults, and AUTO_RUN=0 with short
// counts and STEP_CYCLES=3) share stimulus and are compared every cycle against a
// behavioural model, with directed checks at the documented timing points.

module tb_cpu_clk_ctrl;

    localparam int ST_WAIT = 0;
    localparam int ST_RST  = 1;
    localparam int ST_HALT = 2;
    localparam int ST_RUN  = 3;
    localparam int ST_STEP = 4;

    typedef struct {
        int unsigned ls;
        int unsigned rc;
        int unsigned sc;
        bit          ar;
        int          st;
        int unsigned cnt;
        int unsigned steps;
        bit          rstn;
        bit          en;
        logic [31:0] cyc;
    } model_t;

    logic        cpu_clk;
    logic        rst_n;
    logic        clk_lock;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        bp_hit;
    logic        a_rst_n, a_en, b_rst_n, b_en;
    logic [2:0]  a_state, b_state;
    logic [31:0] a_cyc, b_cyc;

    int n_checks = 0;
    int n_fails  = 0;

    model_t m_a, m_b;
    bit     h_lock1, h_lock2, h_run1, h_run2, h_step1, h_step2;
    bit     skip_a_cyc = 1'b0;

    cpu_clk_ctrl u_dut_a (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .clk_lock   (clk_lock),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .bp_hit     (bp_hit),
        .cpu_rst_n  (a_rst_n),
        .cpu_en     (a_en),
        .ctrl_state (a_state),
        .cycle_cnt  (a_cyc)
    );

    cpu_clk_ctrl #(
        .LOCK_STABLE (4),
        .RST_CYCLES  (5),
        .STEP_CYCLES (3),
        .AUTO_RUN    (1'b0)
    ) u_dut_b (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .clk_lock   (clk_lock),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .bp_hit     (bp_hit),
        .cpu_rst_n  (b_rst_n),
        .cpu_en     (b_en),
        .ctrl_state (b_state),
        .cycle_cnt  (b_cyc)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic model_t model_init(int unsigned ls, int unsigned rc, int unsigned sc,
                                          bit ar);
        model_t m;
        m.ls = ls; m.rc = rc; m.sc = sc; m.ar = ar;
        m.st = ST_WAIT; m.cnt = 0; m.steps = 0;
        m.rstn = 1'b0; m.en = 1'b0; m.cyc = '0;
        return m;
    endfunction

    // One rising edge of the controller as described by its operating rules.
    function automatic model_t model_edge(model_t m, bit lock_s, bit halt, bit bp,
                                          bit run_rise, bit step_rise);
        model_t n = m;
        if (m.st != ST_WAIT && !lock_s) begin
            n.st  = ST_WAIT;
            n.cnt = 0;
        end else begin
            case (m.st)
                ST_WAIT: begin
                    if (!lock_s) n.cnt = 0;
                    else begin
                        n.cnt = m.cnt + 1;
                        if (n.cnt == m.ls) begin n.st = ST_RST; n.cnt = 0; end
                    end
                end
                ST_RST: begin
                    n.cnt = m.cnt + 1;
                    if (n.cnt == m.rc) begin n.st = m.ar ? ST_RUN : ST_HALT; n.cnt = 0; end
                end
                ST_RUN:  if (halt || bp) n.st = ST_HALT;
                ST_HALT: begin
                    if (halt) n.st = ST_HALT;
                    else if (step_rise) begin n.st = ST_STEP; n.steps = m.sc; end
                    else if (run_rise) n.st = ST_RUN;
                end
                ST_STEP: begin
                    n.steps = m.steps - 1;
                    if (n.steps == 0) n.st = ST_HALT;
                end
                default: n.st = ST_WAIT;
            endcase
        end
        n.rstn = (n.st == ST_HALT) || (n.st == ST_RUN) || (n.st == ST_STEP);
        n.en   = (n.st == ST_RUN) || (n.st == ST_STEP);
        if (!n.rstn) n.cyc = '0;
        else if (m.en) n.cyc = m.cyc + 32'd1;
        return n;
    endfunction

    task automatic compare_dut(input string tag, input logic [2:0] st, input logic rstn,
                               input logic en, input logic [31:0] cyc, input model_t m,
                               input bit skip_cyc);
        check_eq({tag, ".state"}, 32'(st), 32'(m.st));
        check_eq({tag, ".cpu_rst_n"}, 32'(rstn), 32'(m.rstn));
        check_eq({tag, ".cpu_en"}, 32'(en), 32'(m.en));
        if (!skip_cyc) check_eq({tag, ".cycle_cnt"}, cyc, m.cyc);
    endtask

    // Advance one clock edge, step the model with the inputs the DUT sampled, then
    // compare 1 time unit after the edge.
    task automatic tick();
        bit lock_s, run_rise, step_rise;
        @(posedge cpu_clk);
        if (!rst_n) begin
            m_a = model_init(m_a.ls, m_a.rc, m_a.sc, m_a.ar);
            m_b = model_init(m_b.ls, m_b.rc, m_b.sc, m_b.ar);
            {h_lock1, h_lock2, h_run1, h_run2, h_step1, h_step2} = '0;
        end else begin
            lock_s    = h_lock2;
            run_rise  = h_run1 & ~h_run2;
            step_rise = h_step1 & ~h_step2;
            m_a = model_edge(m_a, lock_s, halt_req, bp_hit, run_rise, step_rise);
            m_b = model_edge(m_b, lock_s, halt_req, bp_hit, run_rise, step_rise);
            h_lock2 = h_lock1; h_lock1 = clk_lock;
            h_run2  = h_run1;  h_run1  = run_req;
            h_step2 = h_step1; h_step1 = step_req;
        end
        #1;
        compare_dut("a", a_state, a_rst_n, a_en, a_cyc, m_a, skip_a_cyc);
        compare_dut("b", b_state, b_rst_n, b_en, b_cyc, m_b, 1'b0);
    endtask

    initial begin
        int          en_cnt;
        int          lock_low;
        logic [31:0] wrap_v0;

        m_a = model_init(8, 16, 1, 1'b1);
        m_b = model_init(4, 5, 3, 1'b0);
        rst_n = 1'b0; clk_lock = 1'b0;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; bp_hit = 1'b0;

        // Reset values
        repeat (3) tick();
        check_eq("reset.a_state", 32'(a_state), 32'd0);
        check_eq("reset.a_rst_n", 32'(a_rst_n), 32'd0);
        check_eq("reset.a_en", 32'(a_en), 32'd0);
        check_eq("reset.a_cyc", a_cyc, 32'd0);
        check_eq("reset.b_state", 32'(b_state), 32'd0);
        check_eq("reset.b_cyc", b_cyc, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Power-up with defaults: lock rises before edge 0
        clk_lock = 1'b1;
        for (int e = 0; e <= 35; e++) begin
            tick();
            if (e == 8)  check_eq("pwr.state_e8", 32'(a_state), 32'd0);
            if (e == 9)  check_eq("pwr.state_e9", 32'(a_state), 32'd1);
            if (e == 24) check_eq("pwr.rst_n_e24", 32'(a_rst_n), 32'd0);
            if (e == 25) begin
                check_eq("pwr.rst_n_e25", 32'(a_rst_n), 32'd1);
                check_eq("pwr.en_e25", 32'(a_en), 32'd1);
            end
            if (e == 35) check_eq("pwr.cyc_e35", a_cyc, 32'd10);
        end
        check_eq("pwr.b_halt", 32'(b_state), 32'd2);

        // Single step on instance b (STEP_CYCLES=3), second request inside STEP ignored
        en_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            if (e == 0) step_req = 1'b1;
            if (e == 2) step_req = 1'b0;
            if (e == 3) step_req = 1'b1;
            tick();
            if (b_en) en_cnt++;
        end
        step_req = 1'b0;
        check_eq("step.en_cycles", 32'(en_cnt), 32'd3);
        check_eq("step.cyc", b_cyc, 32'd3);
        check_eq("step.halt", 32'(b_state), 32'd2);
        repeat (2) tick();

        // Breakpoint in RUN, then resume with a run_req rise
        bp_hit = 1'b1;
        tick();
        bp_hit = 1'b0;
        check_eq("bp.state", 32'(a_state), 32'd2);
        check_eq("bp.en", 32'(a_en), 32'd0);
        run_req = 1'b1;
        tick();
        check_eq("resume.state_k", 32'(a_state), 32'd2);
        tick();
        check_eq("resume.state_k1", 32'(a_state), 32'd3);
        check_eq("resume.en_k1", 32'(a_en), 32'd1);

        // Halt, then simultaneous run+step rise: step wins
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; run_req = 1'b0;
        repeat (2) tick();
        run_req = 1'b1; step_req = 1'b1;
        repeat (2) tick();
        check_eq("prio.a_step", 32'(a_state), 32'd4);
        check_eq("prio.b_step", 32'(b_state), 32'd4);
        run_req = 1'b0; step_req = 1'b0;
        repeat (6) tick();
        // Same with halt_req held: stays HALT
        halt_req = 1'b1;
        tick();
        run_req = 1'b1; step_req = 1'b1;
        repeat (3) tick();
        check_eq("prio.a_halt", 32'(a_state), 32'd2);
        check_eq("prio.b_halt", 32'(b_state), 32'd2);
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
        repeat (2) tick();

        // Into RUN, then force the cycle counter to its maximum and watch it wrap
        run_req = 1'b1;
        repeat (5) tick();
        force u_dut_a.r_cycle_cnt = 32'hFFFF_FFFF;
        skip_a_cyc = 1'b1;
        tick();
        release u_dut_a.r_cycle_cnt;
        #1;
        // After release the counter holds either the forced value or the value the
        // flop computed from it during the forced edge; both must be consistent.
        wrap_v0 = a_cyc;
        check_eq("wrap.pre", 32'((wrap_v0 == 32'hFFFF_FFFF) || (wrap_v0 == 32'h0)), 32'd1);
        m_a.cyc = wrap_v0;
        skip_a_cyc = 1'b0;
        tick();
        check_eq("wrap.post", a_cyc, (wrap_v0 == 32'hFFFF_FFFF) ? 32'h0 : 32'h1);
        run_req = 1'b0;
        tick();

        // Lock loss in RUN: WAIT_LOCK after 3 edges
        clk_lock = 1'b0;
        tick();
        tick();
        check_eq("loss.state_k1", 32'(a_state), 32'd3);
        tick();
        check_eq("loss.state_k2", 32'(a_state), 32'd0);
        check_eq("loss.rst_n", 32'(a_rst_n), 32'd0);
        check_eq("loss.en", 32'(a_en), 32'd0);
        check_eq("loss.cyc", a_cyc, 32'd0);
        repeat (2) tick();

        // Lock glitch: high 5 edges, low 1, high again
        for (int e = 0; e <= 16; e++) begin
            clk_lock = (e == 5) ? 1'b0 : 1'b1;
            tick();
            if (e == 14) check_eq("glitch.state_e14", 32'(a_state), 32'd0);
            if (e == 15) check_eq("glitch.state_e15", 32'(a_state), 32'd1);
        end
        repeat (30) tick();

        // Randomized traffic against the model
        lock_low = 0;
        for (int i = 0; i < 800; i++) begin
            if (lock_low > 0) begin
                clk_lock = 1'b0;
                lock_low--;
            end else begin
                clk_lock = 1'b1;
                if ($urandom_range(0, 119) == 0) lock_low = $urandom_range(1, 3);
            end
            halt_req = ($urandom_range(0, 19) == 0);
            bp_hit   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) run_req = ~run_req;
            if ($urandom_range(0, 4) == 0) step_req = ~step_req;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Clock-domain controller for the CPU core clock. It runs on the PLL output clock and qualifies PLL lock through a synchronizer and a stability filter. It then sequences a stretched CPU reset and gates core activity with a clock-enable under RUN / HALT / single-STEP control. It sits between the PLL clock module and the single-cycle CPU, and replaces plain lock-ANDed clocking with a glitch-free enable scheme plus debug control.

## Interface
Parameters:
- LOCK_STABLE, 8: consecutive synchronized-lock cycles required before leaving WAIT_LOCK (≥1).
- RST_CYCLES, 16: cycles cpu_rst_n is held low after lock qualifies (≥1).
- STEP_CYCLES, 1: enabled cycles per single-step request (≥1).
- AUTO_RUN, 1: 1 = enter RUN after reset sequence, 0 = enter HALT.

Ports:
- cpu_clk  input  1  PLL output clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- clk_lock  input  1  PLL locked, asynchronous to cpu_clk.
- run_req  input  1  level; rising edge requests RUN.
- halt_req  input  1  level; high requests HALT.
- step_req  input  1  level; rising edge requests one step.
- bp_hit  input  1  single-cycle breakpoint pulse from CPU.
- cpu_rst_n  output  1  registered active-low CPU reset.
- cpu_en  output  1  registered CPU clock-enable.
- ctrl_state  output  3  current state: WAIT_LOCK=0, RST_HOLD=1, HALT=2, RUN=3, STEP=4.
- cycle_cnt  output  32  count of cycles with cpu_en=1.

## Operation
- clk_lock passes through 2 flops → lock_s. run_req and step_req are registered once for edge detect: rise = req & ~req_d.
- WAIT_LOCK: stable counter increments while lock_s=1 and clears when lock_s=0. When it reaches LOCK_STABLE, go to RST_HOLD and clear the counter.
- RST_HOLD: count RST_CYCLES cycles, then go to RUN if AUTO_RUN=1, else to HALT.
- RUN: halt_req=1 or bp_hit=1 → HALT. Otherwise stay.
- HALT: priority halt_req > step rise > run rise. If halt_req=1, stay. Else a step rise → STEP with step counter loaded to STEP_CYCLES. Else a run rise → RUN.
- STEP: the step counter decrements each cycle. After STEP_CYCLES cycles, go to HALT. halt_req, bp_hit, run_req and step_req are ignored in STEP.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK → WAIT_LOCK on the next edge. This overrides all requests.
- Outputs are registered from the next state:
  - cpu_rst_n = 1 only in HALT, RUN, STEP.
  - cpu_en = 1 only in RUN, STEP.
- cycle_cnt:
  - Cleared while cpu_rst_n=0.
  - Increments by 1 each cycle cpu_en=1.
  - Wraps from 0xFFFFFFFF to 0.
- Unused state encodings (5–7) → WAIT_LOCK.

## Timing
- Reset values (asynchronous): ctrl_state=WAIT_LOCK, cpu_rst_n=0, cpu_en=0, cycle_cnt=0. All synchronizer, edge and count registers are 0.
- Lock latency:
  - clk_lock rises before edge 0. lock_s=1 after edge 1.
  - RST_HOLD is entered after edge 1+LOCK_STABLE.
  - cpu_rst_n rises RST_CYCLES edges later, together with cpu_en (AUTO_RUN=1).
- Halt: halt_req or bp_hit sampled high at edge k → cpu_en=0 after edge k. The CPU is enabled during the cycle the request was present.
- Run/step: the edge detector adds 1 cycle.
  - req rises before edge k → rise is seen at edge k+1.
  - cpu_en=1 after edge k+1, for STEP_CYCLES cycles in STEP.
- cpu_en and cpu_rst_n change only on cpu_clk rising edges, so they are glitch-free.
- Simultaneous lock loss and any request: lock loss wins.

## Test plan
- Power-up, AUTO_RUN=1, defaults:
  - clk_lock rises before edge 0 → ctrl_state=1 after edge 9.
  - cpu_rst_n=1 and cpu_en=1 after edge 25.
  - cycle_cnt reaches 10 after edge 35.
- Lock glitch: lock high for 5 cycles, low 1, high again → stable counter restarts and RST_HOLD entry is delayed by 6+sync cycles; cpu_rst_n stays 0 throughout.
- AUTO_RUN=0, STEP_CYCLES=3, step_req pulse in HALT → cpu_en high exactly 3 cycles, cycle_cnt +3, back to HALT. A second step_req during STEP is ignored.
- RUN with bp_hit pulse at edge k → ctrl_state=HALT and cpu_en=0 after edge k. run_req rise then resumes RUN 2 edges after the request.
- HALT with run_req and step_req rising together → STEP taken. With halt_req also high → stays HALT.
- Lock loss in RUN → WAIT_LOCK after 3 edges (sync + FSM): cpu_rst_n=0, cpu_en=0, cycle_cnt=0. Force cycle_cnt to 0xFFFFFFFF in RUN → wraps to 0.
